// File: rtl/alu_sequencer.sv
// Multi-byte ALU command driver: feeds an 8-bit ALU one byte per cycle, chains carry, returns result.
// Optional ALUSEQ_OVERFLOW_EN adds o_res_v (signed overflow of the top byte for ADD/SUB).
module alu_sequencer #(
  parameter int NBYTES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [2:0]            i_cmd_op,
  input  logic [8*NBYTES-1:0]   i_cmd_a,
  input  logic [8*NBYTES-1:0]   i_cmd_b,
  input  logic                  i_cmd_c,
  output logic [7:0]            o_sb,
  output logic [7:0]            o_db,
  output logic                  o_sb_add,
  output logic                  o_db_add,
  output logic                  o_db_n_add,
  output logic                  o_0_add,
  output logic                  o_1_addc,
  output logic                  o_sums,
  output logic                  o_ands,
  output logic                  o_eors,
  output logic                  o_ors,
  output logic                  o_srs,
  input  logic [7:0]            i_add,
  input  logic                  i_acr,
  output logic                  o_res_valid,
  input  logic                  i_res_ready,
`ifdef ALUSEQ_OVERFLOW_EN
  output logic                  o_res_v,
`endif
  output logic [8*NBYTES-1:0]   o_res,
  output logic                  o_res_c
);

  localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2,
    OP_OR  = 3'd3, OP_EOR = 3'd4, OP_SHR = 3'd5
  } op_e;

  typedef struct packed {
    logic [7:0] sb;
    logic [7:0] db;
    logic       sb_add;
    logic       db_add;
    logic       db_n_add;
    logic       addc;
    logic       sums;
    logic       ands;
    logic       eors;
    logic       ors;
    logic       srs;
  } ctrl_t;

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [NBYTES-1:0][7:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic                    carry_q, carry_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    live_q, live_d;
  logic                    res_c_q, res_c_d;
  ctrl_t                   ctrl_q, ctrl_d;

  logic                    carry_nx;
  logic                    last_byte;
  logic [KW-1:0]           k_nx;
  logic                    op_uses_carry;

`ifdef ALUSEQ_OVERFLOW_EN
  logic                    res_v_q, res_v_d;
  logic                    b_top_eff;
`endif

  function automatic ctrl_t byte_ctrl(input op_e op, input logic [7:0] a,
                                      input logic [7:0] b, input logic cin);
    ctrl_t c;
    c        = '0;
    c.sb     = a;
    c.db     = b;
    c.sb_add = 1'b1;
    case (op)
      OP_SUB: begin c.db_n_add = 1'b1; c.sums = 1'b1; c.addc = cin; end
      OP_AND: begin c.db_add = 1'b1; c.ands = 1'b1; end
      OP_OR:  begin c.db_add = 1'b1; c.ors  = 1'b1; end
      OP_EOR: begin c.db_add = 1'b1; c.eors = 1'b1; end
      OP_SHR: begin c.db = 8'h00; c.srs = 1'b1; c.addc = cin; end
      default: begin c.db_add = 1'b1; c.sums = 1'b1; c.addc = cin; end
    endcase
    return c;
  endfunction

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    carry_d       = carry_q;
    k_d           = k_q;
    live_d        = live_q;
    res_d         = res_q;
    res_c_d       = res_c_q;
    ctrl_d        = '0;
    op_uses_carry = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SHR);
    carry_nx      = op_uses_carry ? i_acr : carry_q;
    last_byte     = (op_q == OP_SHR) ? (k_q == '0) : (k_q == K_LAST);
    k_nx          = (op_q == OP_SHR) ? (k_q - KW'(1)) : (k_q + KW'(1));
`ifdef ALUSEQ_OVERFLOW_EN
    res_v_d       = res_v_q;
    b_top_eff     = b_q[K_LAST][7] ^ (op_q == OP_SUB);
`endif

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          // Reserved opcodes run as ADD.
          op_d    = (i_cmd_op > 3'd5) ? OP_ADD : op_e'(i_cmd_op);
          a_d     = i_cmd_a;
          b_d     = i_cmd_b;
          carry_d = i_cmd_c;
          k_d     = (i_cmd_op == 3'd5) ? K_LAST : '0;
          live_d  = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!live_q) begin
          ctrl_d = byte_ctrl(op_q, a_q[k_q], b_q[k_q], carry_q);
          live_d = 1'b1;
        end else begin
          res_d[k_q] = i_add;
          carry_d    = carry_nx;
          if (last_byte) begin
            state_d = S_DONE;
            live_d  = 1'b0;
            res_c_d = op_uses_carry ? carry_nx : 1'b0;
`ifdef ALUSEQ_OVERFLOW_EN
            if ((op_q == OP_ADD) || (op_q == OP_SUB))
              res_v_d = (a_q[K_LAST][7] == b_top_eff) && (i_add[7] != a_q[K_LAST][7]);
            else
              res_v_d = 1'b0;
`endif
          end else begin
            // Next byte's controls use the carry just produced by the ALU.
            k_d    = k_nx;
            ctrl_d = byte_ctrl(op_q, a_q[k_nx], b_q[k_nx], carry_nx);
          end
        end
      end
      S_DONE: begin
        if (i_res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_ADD;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      live_q  <= 1'b0;
      res_q   <= '0;
      res_c_q <= 1'b0;
      ctrl_q  <= '0;
`ifdef ALUSEQ_OVERFLOW_EN
      res_v_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      live_q  <= live_d;
      res_q   <= res_d;
      res_c_q <= res_c_d;
      ctrl_q  <= ctrl_d;
`ifdef ALUSEQ_OVERFLOW_EN
      res_v_q <= res_v_d;
`endif
    end
  end

  assign o_cmd_ready = (state_q == S_IDLE);
  assign o_res_valid = (state_q == S_DONE);
  assign o_res       = res_q;
  assign o_res_c     = res_c_q;
  assign o_sb        = ctrl_q.sb;
  assign o_db        = ctrl_q.db;
  assign o_sb_add    = ctrl_q.sb_add;
  assign o_db_add    = ctrl_q.db_add;
  assign o_db_n_add  = ctrl_q.db_n_add;
  assign o_0_add     = 1'b0;
  assign o_1_addc    = ctrl_q.addc;
  assign o_sums      = ctrl_q.sums;
  assign o_ands      = ctrl_q.ands;
  assign o_eors      = ctrl_q.eors;
  assign o_ors       = ctrl_q.ors;
  assign o_srs       = ctrl_q.srs;
`ifdef ALUSEQ_OVERFLOW_EN
  assign o_res_v     = res_v_q;
`endif

endmodule
